// File: rtl/gait_pkg.sv
// Shared types and widths for the keyframe gait sequencer.
// Included by gait_lerp and servo_gait_sequencer.
package gait_pkg;

  localparam int SERVO_W = 5;
  localparam int FRAME_W = 4;
  localparam int POS_W   = 16;
  localparam int ADDR_W  = FRAME_W + SERVO_W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    RD_A,
    RD_B,
    CALC,
    EMIT
  } gait_state_t;

  function automatic logic [FRAME_W-1:0] next_frame(
    input logic [FRAME_W-1:0] f,
    input logic [FRAME_W:0]   nf
  );
    return ({1'b0, f} == nf - 1'b1) ? '0 : f + 1'b1;
  endfunction

endpackage

// File: rtl/gait_lerp.sv
// Linear interpolation a -> b by step/2**STEP_SHIFT, floor rounding.
// Optional saturation to [POS_MIN,POS_MAX] when SERVO_CLAMP_EN is defined.
module gait_lerp
  import gait_pkg::*;
#(
  parameter int STEP_SHIFT = 4,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 65535
) (
  input  logic [POS_W-1:0]      a,
  input  logic [POS_W-1:0]      b,
  input  logic [STEP_SHIFT-1:0] step,
  output logic [POS_W-1:0]      pos
);

  localparam int PW = POS_W + STEP_SHIFT + 2;
`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  localparam logic signed [PW-1:0] LO = PW'(POS_MIN);
  localparam logic signed [PW-1:0] HI = PW'(POS_MAX);

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum;

  always_comb begin
    ax   = $signed({{(PW-POS_W){1'b0}}, a});
    diff = $signed({{(PW-POS_W){1'b0}}, b}) - ax;
    prod = diff * $signed({{(PW-STEP_SHIFT){1'b0}}, step});
    sum  = ax + (prod >>> STEP_SHIFT);
    if (CLAMP_EN && sum < LO) begin
      sum = LO;
    end else if (CLAMP_EN && sum > HI) begin
      sum = HI;
    end
    pos = sum[POS_W-1:0];
  end

endmodule

// File: rtl/servo_gait_sequencer.sv
// Keyframe gait sequencer: per-servo table, lerp sweep per tick.
// Build option SERVO_CLAMP_EN saturates positions to [POS_MIN,POS_MAX].
module servo_gait_sequencer
  import gait_pkg::*;
#(
  parameter int NUM_SERVOS = 24,
  parameter int MAX_FRAMES = 16,
  parameter int STEP_SHIFT = 4,
  parameter int TICK_DIV   = 100000,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  kf_addr,
  input  logic [POS_W-1:0]   kf_data,
  input  logic               kf_we,
  input  logic [FRAME_W:0]   num_frames,
  input  logic               start,
  input  logic               stop,
  output logic [SERVO_W-1:0] servo_select,
  output logic [POS_W-1:0]   servo_position,
  output logic               servo_update,
  output logic               busy,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_done
);

  localparam int TW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam logic [SERVO_W-1:0] LAST_SERVO = SERVO_W'(NUM_SERVOS - 1);
  localparam logic [FRAME_W:0] NF_MAX = (FRAME_W+1)'(MAX_FRAMES);

  gait_state_t             state;
  logic [FRAME_W:0]        nf_q;
  logic [SERVO_W-1:0]      servo_q;
  logic [STEP_SHIFT-1:0]   step_q;
  logic [TW-1:0]           cnt_q;
  logic                    tick;
  logic                    tick_pend;
  logic                    stop_pend;
  logic [POS_W-1:0]        a_q;
  logic [POS_W-1:0]        rd_q;
  logic [POS_W-1:0]        lerp_pos;
  logic [FRAME_W-1:0]      nxt;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [POS_W-1:0]        mem [2**ADDR_W];

  assign nxt   = next_frame(frame, nf_q);
  assign tick  = busy && (cnt_q == TW'(TICK_DIV - 1));
  assign rd_en = (state == RD_A) || (state == RD_B);
  assign rd_addr = (state == RD_B) ? {nxt, servo_q}
                                   : {frame, servo_q};

  // Read-before-write: a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (kf_we) mem[kf_addr] <= kf_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  gait_lerp #(
    .STEP_SHIFT(STEP_SHIFT),
    .POS_MIN   (POS_MIN),
    .POS_MAX   (POS_MAX)
  ) u_lerp (
    .a   (a_q),
    .b   (rd_q),
    .step(step_q),
    .pos (lerp_pos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      nf_q           <= '0;
      servo_q        <= '0;
      step_q         <= '0;
      cnt_q          <= '0;
      tick_pend      <= 1'b0;
      stop_pend      <= 1'b0;
      a_q            <= '0;
      servo_select   <= '0;
      servo_position <= '0;
      servo_update   <= 1'b0;
      busy           <= 1'b0;
      frame          <= '0;
      frame_done     <= 1'b0;
    end else begin
      servo_update <= 1'b0;
      frame_done   <= 1'b0;
      if (busy) cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (busy && stop) stop_pend <= 1'b1;
      if (tick && state != WAIT_TICK) tick_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_frames == '0) nf_q <= 1;
            else if (num_frames > NF_MAX) nf_q <= NF_MAX;
            else nf_q <= num_frames;
            frame   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            servo_q <= '0;
            busy    <= 1'b1;
            state   <= RD_A;
          end
        end
        WAIT_TICK: begin
          if (tick || tick_pend) begin
            tick_pend <= tick && tick_pend;
            state     <= RD_A;
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          a_q   <= rd_q;
          state <= CALC;
        end
        CALC: begin
          servo_select   <= servo_q;
          servo_position <= lerp_pos;
          servo_update   <= 1'b1;
          state          <= EMIT;
        end
        EMIT: begin
          if (servo_q != LAST_SERVO) begin
            servo_q <= servo_q + 1'b1;
            state   <= RD_A;
          end else begin
            servo_q <= '0;
            if (step_q != '1) begin
              step_q <= step_q + 1'b1;
              state  <= WAIT_TICK;
            end else begin
              step_q     <= '0;
              frame      <= nxt;
              frame_done <= 1'b1;
              if (stop_pend) begin
                busy      <= 1'b0;
                stop_pend <= 1'b0;
                tick_pend <= 1'b0;
                state     <= IDLE;
              end else begin
                state <= WAIT_TICK;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_gait_sequencer.sv
// Randomized bench for servo_gait_sequencer against a keyframe-lerp model.
// Honours SERVO_CLAMP_EN (POS_MAX=1500 in that build).
module tb_servo_gait_sequencer;

  localparam int NS = 8;
  localparam int TD = 20;
  localparam int NSTEP = 16;
`ifdef SERVO_CLAMP_EN
  localparam int PMAX = 1500;
`else
  localparam int PMAX = 65535;
`endif

  logic        clk;
  logic        rst;
  logic [8:0]  kf_addr;
  logic [15:0] kf_data;
  logic        kf_we;
  logic [4:0]  num_frames;
  logic        start;
  logic        stop;
  logic [4:0]  servo_select;
  logic [15:0] servo_position;
  logic        servo_update;
  logic        busy;
  logic [3:0]  frame;
  logic        frame_done;

  servo_gait_sequencer #(
    .NUM_SERVOS(NS),
    .MAX_FRAMES(16),
    .STEP_SHIFT(4),
    .TICK_DIV  (TD),
    .POS_MIN   (0),
    .POS_MAX   (PMAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .kf_addr       (kf_addr),
    .kf_data       (kf_data),
    .kf_we         (kf_we),
    .num_frames    (num_frames),
    .start         (start),
    .stop          (stop),
    .servo_select  (servo_select),
    .servo_position(servo_position),
    .servo_update  (servo_update),
    .busy          (busy),
    .frame         (frame),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int bad;
  int tbl [16][32];
  int mk, mi, mnf;
  int cyc, last, fd_cnt, upd_cnt;
  int s0_log [64];

  task automatic check(input string tag, input int got, input int exp);
    vec++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int p);
    if (p < 0) return 0;
    if (p > PMAX) return PMAX;
    return p;
  endfunction

  function automatic int model(input int k, input int s);
    int f, st, a, b, d, q;
    f  = (k / NSTEP) % mnf;
    st = k % NSTEP;
    a  = tbl[f][s];
    b  = tbl[(f + 1) % mnf][s];
    d  = (b - a) * st;
    q  = (d >= 0) ? d / NSTEP : -((-d + NSTEP - 1) / NSTEP);
    return clampv(a + q);
  endfunction

  task automatic observe();
    int e, a, b, lo, hi, f;
    cyc++;
    if (servo_update) begin
      upd_cnt++;
      e = model(mk, mi);
      f = (mk / NSTEP) % mnf;
      a = tbl[f][mi];
      b = tbl[(f + 1) % mnf][mi];
      lo = clampv((a < b) ? a : b);
      hi = clampv((a < b) ? b : a);
      check("select", int'(servo_select), mi);
      check("position", int'(servo_position), e);
      check("in_range", int'(servo_position >= lo &&
                             servo_position <= hi), 1);
      if (mi != 0) check("gap_servo", cyc - last, 4);
      else if (mk != 0) check("gap_sweep", cyc - last, 5);
      if (mi == 0 && mk < 64) s0_log[mk] = int'(servo_position);
      last = cyc;
      mi++;
      if (mi == NS) begin
        mi = 0;
        mk++;
      end
    end
    if (frame_done) begin
      fd_cnt++;
      check("fd_step", mk % NSTEP, 0);
      check("fd_frame", int'(frame), (mk / NSTEP) % mnf);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
  endtask

  task automatic wr(input int f, input int s, input int v);
    kf_addr = {4'(f), 5'(s)};
    kf_data = 16'(v);
    kf_we   = 1'b1;
    cycle();
    kf_we   = 1'b0;
    tbl[f][s] = v;
  endtask

  task automatic begin_run(input int nf, input bit with_stop);
    num_frames = 5'(nf);
    start = 1'b1;
    stop  = with_stop;
    mk = 0;
    mi = 0;
    fd_cnt = 0;
    mnf = (nf == 0) ? 1 : nf;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run_to(input int k);
    int n;
    n = 0;
    while (mk < k && n < 4000) begin
      cycle();
      n++;
    end
    if (mk < k) check("timeout_run", mk, k);
  endtask

  task automatic stop_and_drain(input int t);
    int n, u;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    n = 0;
    while (busy && n < 4000) begin
      cycle();
      n++;
    end
    check("idle", int'(busy), 0);
    check("fd_with_busy", int'(frame_done), 1);
    check("end_sweep", mk, (t / NSTEP + 1) * NSTEP);
    u = upd_cnt;
    repeat (60) cycle();
    check("no_upd_after_stop", upd_cnt, u);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"}, int'(servo_select), 0);
    check({tag, "_pos"}, int'(servo_position), 0);
    check({tag, "_upd"}, int'(servo_update), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame"}, int'(frame), 0);
    check({tag, "_fd"}, int'(frame_done), 0);
  endtask

  initial begin
    int nf, t;
    vec = 0; bad = 0;
    cyc = 0; last = 0; fd_cnt = 0; upd_cnt = 0;
    mk = 0; mi = 0; mnf = 1;
    rst = 1'b1;
    kf_addr = '0; kf_data = '0; kf_we = 1'b0;
    num_frames = '0; start = 1'b0; stop = 1'b0;
    for (int f = 0; f < 16; f++)
      for (int s = 0; s < 32; s++) tbl[f][s] = 0;
    repeat (3) cycle();
    check_zero("reset");
    rst = 1'b0;
    for (int f = 0; f < 16; f++)
      for (int s = 0; s < NS; s++) wr(f, s, 0);

    // ascending ramp on servo 0
    wr(0, 0, 1000);
    wr(1, 0, 2000);
    for (int s = 1; s < NS; s++) begin
      wr(0, s, int'($urandom_range(0, 65535)));
      wr(1, s, int'($urandom_range(0, 65535)));
    end
    begin_run(2, 1'b0);
    check("busy_after_start", int'(busy), 1);
    run_to(17);
    stop_and_drain(17);
    check("asc_fd_count", fd_cnt, 2);
    check("asc_end_frame", int'(frame), 0);
    check("asc_step0", s0_log[0], clampv(1000));
    check("asc_step1", s0_log[1], clampv(1062));
    check("asc_step2", s0_log[2], clampv(1125));
    check("asc_step15", s0_log[15], clampv(1937));
    check("asc_frame1", s0_log[16], clampv(2000));

    // descending ramp; start and stop together
    wr(0, 0, 2000);
    wr(1, 0, 1000);
    begin_run(2, 1'b1);
    check("start_wins", int'(busy), 1);
    run_to(5);
    stop_and_drain(5);
    check("desc_step1", s0_log[1], clampv(1937));
    check("desc_step15", s0_log[15], clampv(1062));

    // three-frame loop wraps back to frame 0
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < NS; s++)
        wr(f, s, int'($urandom_range(0, 65535)));
    begin_run(3, 1'b0);
    run_to(41);
    stop_and_drain(41);
    check("loop3_fd_count", fd_cnt, 3);
    check("loop3_end_frame", int'(frame), 0);

    // random loops, including num_frames=0 and 1
    for (int it = 0; it < 4; it++) begin
      nf = (it < 2) ? it : int'($urandom_range(2, 5));
      for (int f = 0; f < 5; f++)
        for (int s = 0; s < NS; s++)
          wr(f, s, int'($urandom_range(0, 65535)));
      begin_run(nf, 1'b0);
      t = int'($urandom_range(1, 20));
      run_to(t);
      stop_and_drain(t);
    end

    // reset while an update is on the outputs
    begin_run(2, 1'b0);
    run_to(3);
    check("upd_before_rst", int'(servo_update), 1);
    rst = 1'b1;
    cycle();
    check_zero("midrst");
    rst = 1'b0;
    repeat (10) cycle();
    check("idle_after_rst", int'(busy), 0);
    begin_run(1, 1'b0);
    run_to(3);
    stop_and_drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
